pattern_det_ctrl: RTL and testbench
===================================

PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cfg_valid  input  1  configuration write request
- cfg_ready  output  1  configuration can be accepted
- cfg_pattern  input  4  target pattern; bit 3 is the oldest bit
- cfg_count  input  8  matches required for done; 0 means unlimited
- start  input  1  begin a detection run
- stop  input  1  abort the current run
- x  input  1  serial data bit
- x_valid  input  1  x is a valid sample this cycle
- z  output  1  one-cycle match pulse
- busy  output  1  run in progress
- done  output  1  required match count reached
- match_cnt  output  8  matches counted in the current run

Function
REQ-003 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE or DONE -> RUN on start
- RUN -> IDLE on stop
- RUN -> DONE when a match brings match_cnt equal to a nonzero cfg_count
REQ-004 cfg_ready SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-005 A configuration handshake SHALL occur when cfg_valid and cfg_ready are both 1; the handshake latches cfg_pattern and cfg_count into internal registers. cfg_valid during RUN SHALL be ignored.
REQ-006 If cfg_valid and start are both 1 in IDLE or DONE, the new configuration SHALL be latched and the run SHALL use it.
REQ-007 Entering RUN SHALL, in the same edge:
- clear match_cnt, the 4-bit history shift register and the fill counter (0..4)
- deassert done
REQ-008 In RUN, each cycle with x_valid=1 SHALL shift x into the history LSB and increment the fill counter, saturating at 4. Cycles with x_valid=0 SHALL change nothing.
REQ-009 A match SHALL be detected when the fill counter is already 4, or reaches 4 on this sample, and the updated history equals the pattern register.
REQ-010 On a match, z SHALL be 1 for exactly the cycle after the completing sample, and match_cnt SHALL increment on that same edge, wrapping 255->0.
REQ-011 z SHALL never assert outside RUN, and never for the sample edge on which stop is sampled.
REQ-012 busy SHALL be 1 exactly while in RUN. done SHALL be 1 exactly while in DONE.
REQ-013 match_cnt SHALL hold its value in IDLE (after stop) and in DONE until the next start.
REQ-014 stop and start together in RUN: stop SHALL win.
REQ-015 start in RUN (without stop) SHALL be ignored.
REQ-016 Transition to DONE SHALL occur on the same edge that asserts z for the final match; x samples after that edge SHALL be ignored.
REQ-017 With cfg_count=0, the block SHALL remain in RUN until stop, and match_cnt SHALL wrap.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL set:
- state IDLE
- pattern register 4'b1011, count register 8'd1
- history 0, fill counter 0
- z=0, busy=0, done=0, match_cnt=0, cfg_ready=1
REQ-019 rst SHALL override every other input, including mid-run and during a config handshake; no z pulse SHALL follow a reset edge.

Configuration
REQ-020 Macro PATDET_OVERLAP_EN SHALL select overlap behaviour.
- Defined: after a match, the history and fill counter SHALL be retained, so overlapping matches count ("1011011" yields 2 matches with pattern 1011).
- Undefined: a match SHALL clear the fill counter on the match edge, so the next match needs 4 fresh valid samples ("1011011" yields 1 match).

Verification
REQ-021 The bench SHALL cover:
- Reset, no cfg: start, then x=1,0,1,1 on consecutive valid cycles -> z pulses once, one cycle after the 4th bit; done=1, busy=0, match_cnt=1.
- cfg pattern 4'b1011, count 0: start, then stream 1011011 -> with PATDET_OVERLAP_EN, 2 z pulses and match_cnt=2; without it, 1 pulse and match_cnt=1; busy stays 1 in both cases.
- cfg count 3 in RUN: cfg_valid ignored (cfg_ready=0) and the old pattern remains in effect; stop -> IDLE with match_cnt held.
- x_valid gaps: bits 1,-,0,-,-,1,1 (- = x_valid 0) -> exactly one match; gaps do not break the pattern.
- stop and start asserted together in RUN -> IDLE, no z on that edge; rst asserted mid-run after bits 1,0,1 -> all outputs at reset values, no z afterwards.

Source files
------------

// File: rtl/pattern_det_ctrl.sv
// Serial 4-bit pattern detector with run/stop/done control and match counting.
// Define PATDET_OVERLAP_EN to let consecutive matches share history bits.
module pattern_det_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [3:0] cfg_pattern,
   input  logic [7:0] cfg_count,
   input  logic       start,
   input  logic       stop,
   input  logic       x,
   input  logic       x_valid,
   output logic       z,
   output logic       busy,
   output logic       done,
   output logic [7:0] match_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] pat_q, pat_d;
   logic [7:0] req_q, req_d;
   logic [3:0] hist_q, hist_d;
   logic [2:0] fill_q, fill_d;
   logic [7:0] cnt_q, cnt_d;
   logic       z_q, z_d;

   logic [3:0] hist_shift;
   logic [2:0] fill_inc;
   logic [7:0] cnt_inc;
   logic       hit;

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      req_d      = req_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      cnt_d      = cnt_q;
      z_d        = 1'b0;
      hist_shift = {hist_q[2:0], x};
      fill_inc   = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
      cnt_inc    = cnt_q + 8'd1;
      hit        = (fill_inc == 3'd4) && (hist_shift == pat_q);

      case (state_q)
         S_RUN: begin
            // stop takes priority over both start and any completing sample
            if (stop) begin
               state_d = S_IDLE;
            end else if (x_valid) begin
               hist_d = hist_shift;
               fill_d = fill_inc;
               if (hit) begin
                  z_d   = 1'b1;
                  cnt_d = cnt_inc;
`ifdef PATDET_OVERLAP_EN
                  fill_d = fill_inc;
`else
                  fill_d = '0;
`endif
                  if ((req_q != '0) && (cnt_inc == req_q)) begin
                     state_d = S_DONE;
                  end
               end
            end
         end
         default: begin
            if (cfg_valid) begin
               pat_d = cfg_pattern;
               req_d = cfg_count;
            end
            if (start) begin
               state_d = S_RUN;
               hist_d  = '0;
               fill_d  = '0;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= 4'b1011;
         req_q   <= 8'd1;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         req_q   <= req_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
      end
   end

   assign z         = z_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign cfg_ready = (state_q != S_RUN);
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl: queue-based reference model checked every
// cycle, plus literal expectations per scenario. Honours PATDET_OVERLAP_EN.
module tb_pattern_det_ctrl;

   logic       clk = 1'b0;
   logic       rst, cfg_valid, cfg_ready, start, stop, x, x_valid;
   logic [3:0] cfg_pattern;
   logic [7:0] cfg_count;
   logic       z, busy, done;
   logic [7:0] match_cnt;

   int checks = 0;
   int errors = 0;
   int zp     = 0;
   bit chk_en = 1'b0;

`ifdef PATDET_OVERLAP_EN
   localparam bit OV = 1'b1;
`else
   localparam bit OV = 1'b0;
`endif

   pattern_det_ctrl dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_count(cfg_count), .start(start),
      .stop(stop), .x(x), .x_valid(x_valid), .z(z), .busy(busy),
      .done(done), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 run, 2 done; hq holds the usable recent bits.
   int m_mode = 0;
   int m_pat  = 11;
   int m_req  = 1;
   int m_cnt  = 0;
   bit m_z    = 1'b0;
   bit hq[$];

   function automatic int qval();
      int v = 0;
      foreach (hq[i]) v = v * 2 + int'(hq[i]);
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_pat = 11; m_req = 1; m_cnt = 0; m_z = 1'b0;
         hq.delete();
      end else begin
         m_z = 1'b0;
         if (m_mode == 1) begin
            if (stop) begin
               m_mode = 0;
            end else if (x_valid) begin
               hq.push_back(x);
               if (hq.size() > 4) void'(hq.pop_front());
               if (hq.size() == 4 && qval() == m_pat) begin
                  m_z   = 1'b1;
                  m_cnt = (m_cnt + 1) % 256;
                  if (!OV) hq.delete();
                  if (m_req != 0 && m_cnt == m_req) m_mode = 2;
               end
            end
         end else begin
            if (cfg_valid) begin
               m_pat = int'(cfg_pattern);
               m_req = int'(cfg_count);
            end
            if (start) begin
               m_mode = 1; m_cnt = 0;
               hq.delete();
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("z",         int'(z),         int'(m_z));
         chk("busy",      int'(busy),      int'(m_mode == 1));
         chk("done",      int'(done),      int'(m_mode == 2));
         chk("cfg_ready", int'(cfg_ready), int'(m_mode != 1));
         chk("match_cnt", int'(match_cnt), m_cnt);
      end
   end

   task automatic drive(input logic r, input logic cv, input logic [3:0] p,
                        input logic [7:0] c, input logic st, input logic sp,
                        input logic xv, input logic xb);
      rst = r; cfg_valid = cv; cfg_pattern = p; cfg_count = c;
      start = st; stop = sp; x_valid = xv; x = xb;
      @(negedge clk);
      if (z) zp++;
   endtask

   task automatic smp(input logic b);
      drive(0, 0, 4'h0, 8'h0, 0, 0, 1, b);
   endtask

   task automatic gap();
      drive(0, 0, 4'h0, 8'h0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(1, 0, 4'h0, 8'h0, 0, 0, 0, 0);
      drive(1, 0, 4'h0, 8'h0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      chk("rst_cnt", int'(match_cnt), 0);

      // Default config after reset: pattern 1011, count 1
      drive(0, 0, 4'h0, 8'h0, 1, 0, 0, 0);
      smp(1); smp(0); smp(1);
      chk("s1_z_early", int'(z), 0);
      smp(1);
      chk("s1_z", int'(z), 1);
      chk("s1_done", int'(done), 1);
      chk("s1_busy", int'(busy), 0);
      chk("s1_cnt", int'(match_cnt), 1);
      chk("s1_model_cnt", m_cnt, 1);
      gap();
      chk("s1_z_once", int'(z), 0);

      // Unlimited count, overlapping stream 1011011
      drive(0, 1, 4'b1011, 8'd0, 1, 0, 0, 0);
      zp = 0;
      smp(1); smp(0); smp(1); smp(1); smp(0); smp(1); smp(1);
      gap();
      chk("s2_pulses", zp, OV ? 2 : 1);
      chk("s2_cnt", int'(match_cnt), OV ? 2 : 1);
      chk("s2_busy", int'(busy), 1);

      // Config during RUN is ignored; old pattern still matches
      chk("s3_ready", int'(cfg_ready), 0);
      drive(0, 1, 4'b0000, 8'd3, 0, 0, 0, 0);
      zp = 0;
      smp(1); smp(0); smp(1); smp(1);
      gap();
      chk("s3_pulses", zp, 1);
      chk("s3_cnt", int'(match_cnt), OV ? 3 : 2);
      drive(0, 0, 4'h0, 8'h0, 0, 1, 0, 0);
      gap();
      chk("s3_busy", int'(busy), 0);
      chk("s3_hold", int'(match_cnt), OV ? 3 : 2);

      // x_valid gaps, then stop+start on a would-be match
      drive(0, 0, 4'h0, 8'h0, 1, 0, 0, 0);
      zp = 0;
      smp(1); gap(); smp(0); gap(); gap(); smp(1); smp(1);
      gap();
      chk("s4_pulses", zp, 1);
      chk("s4_cnt", int'(match_cnt), 1);
      smp(1); smp(0); smp(1);
      drive(0, 0, 4'h0, 8'h0, 1, 1, 1, 1);
      chk("s4_stop_z", int'(z), 0);
      chk("s4_stop_busy", int'(busy), 0);
      chk("s4_stop_cnt", int'(match_cnt), 1);

      // Reset mid-run on a would-be match, then reset config in effect
      drive(0, 0, 4'h0, 8'h0, 1, 0, 0, 0);
      smp(1); smp(0); smp(1);
      drive(1, 1, 4'b0000, 8'd5, 0, 0, 1, 1);
      chk("s5_z", int'(z), 0);
      chk("s5_busy", int'(busy), 0);
      chk("s5_done", int'(done), 0);
      chk("s5_ready", int'(cfg_ready), 1);
      chk("s5_cnt", int'(match_cnt), 0);
      smp(1);
      chk("s5_z_after", int'(z), 0);
      drive(0, 0, 4'h0, 8'h0, 1, 0, 0, 0);
      smp(1); smp(0); smp(1); smp(1);
      chk("s5_done2", int'(done), 1);
      chk("s5_cnt2", int'(match_cnt), 1);

      // Count 2 with all-ones pattern; samples after DONE are ignored
      drive(0, 1, 4'b1111, 8'd2, 1, 0, 0, 0);
      zp = 0;
      for (int i = 0; i < 10; i++) smp(1);
      chk("s6_pulses", zp, 2);
      chk("s6_done", int'(done), 1);
      chk("s6_cnt", int'(match_cnt), 2);

      // Unlimited count wrap of match_cnt
      drive(0, 1, 4'b1111, 8'd0, 1, 0, 0, 0);
      for (int i = 0; i < 1030; i++) smp(1);
      chk("s7_busy", int'(busy), 1);
      chk("s7_wrap", int'(match_cnt), OV ? 3 : 1);
      drive(0, 0, 4'h0, 8'h0, 0, 1, 0, 0);
      gap();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
